// File: rtl/mem_responder_pkg.sv
// Shared definitions for mem_responder: FSM state encoding and the default
// load base address. The load base also sets the CPU reset PC, so both sides
// take it from here.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    LOAD_IDLE = 2'd0,
    LOAD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_LOAD_BASE = 8;

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_responder_mem_array: word storage with one write port and a registered
// read port. The contents are never reset. A read and a write to the same
// address in the same cycle return the old word (read-first).
//   clk    : clock
//   we     : write enable
//   waddr  : write word address
//   wdata  : write data
//   raddr  : read word address
//   rdata  : registered read data
module mem_responder_mem_array #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: the memory that answers the CPU bus. After reset it takes
// program words over a valid/ready port, writing them from LOAD_BASE upward.
// It then hands the memory to the CPU port.
//   clk, rst  : clock; asynchronous active-high reset
//   we/addr/data/out : CPU port. out is registered read data with 1-cycle latency
//   ld_valid/ld_data/ld_last/ld_ready : loader handshake
//   run       : load finished, CPU port live
//   overflow  : sticky; the load wrapped back to LOAD_BASE without ld_last
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LOAD_BASE  = DEFAULT_LOAD_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  run,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(LOAD_BASE);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]   ptr_inc;
  logic                    ld_ready_q;
  logic                    overflow_q;
  logic                    rd_en_q;
  logic                    accept;
  logic                    set_ovf;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // ld_ready is registered and only ever high while in LOAD. It therefore
  // rises on the second edge after reset release and drops on the edge that
  // leaves LOAD.
  assign accept  = ld_valid && ld_ready_q;
  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    set_ovf = 1'b0;
    unique case (state_q)
      LOAD_IDLE: state_d = LOAD;
      LOAD: begin
        if (accept) begin
          if (ld_last) begin
            state_d = RUN;
          end else if (ptr_inc == BASE) begin
            state_d = RUN;
            set_ovf = 1'b1;
          end
        end
      end
      RUN:     state_d = RUN;
      default: state_d = LOAD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD_IDLE;
      ptr_q      <= BASE;
      ld_ready_q <= 1'b0;
      overflow_q <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= (state_q == LOAD) && (state_d == LOAD);
      rd_en_q    <= (state_q == RUN);
      if (accept) begin
        ptr_q <= ptr_inc;
      end
      if (set_ovf) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // The loader owns the write port while loading. The CPU owns it only in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data;
    if (accept) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = ld_data;
    end else if (state_q == RUN) begin
      mem_we = we;
    end
  end

  mem_responder_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (addr),
    .rdata (mem_rdata)
  );

  // rd_en_q marks read data that was captured during RUN. out stays 0 until
  // then, and the unreset array output never reaches the CPU.
  assign out      = rd_en_q ? mem_rdata : '0;
  assign ld_ready = ld_ready_q;
  assign run      = (state_q == RUN);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [5:0]  addr = '0;
  logic [15:0] data = '0;
  logic [15:0] out;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        run;
  logic        overflow;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_WIDTH (6),
    .DATA_WIDTH (16),
    .LOAD_BASE  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .data     (data),
    .out      (out),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .run      (run),
    .overflow (overflow)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got hang, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b0; we = 1'b0; ld_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Offers one word and returns #1 after the edge that accepts it.
  task automatic push(input logic [15:0] d, input logic last);
    int unsigned n;
    n = 0;
    @(negedge clk);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    while (!ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: ld_ready=%b want 1 (data %h)", ld_ready, d);
    end
    @(posedge clk);
    #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic cpu_read(input logic [5:0] a, output logic [15:0] q);
    @(negedge clk);
    addr = a; we = 1'b0;
    @(posedge clk);
    #1;
    q = out;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; data = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out: got %h want 0000", out); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    n_cmp++; if (run !== 1'b0) begin n_err++; $display("FAIL reset_run: got %b want 0", run); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL ready_edge1: got %b want 0", ld_ready); end
    @(posedge clk); #1;
    n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL ready_edge2: got %b want 1", ld_ready); end
    n_cmp++; if (run !== 1'b0) begin n_err++; $display("FAIL ready_edge2_run: got %b want 0", run); end
  endtask

  task automatic test_basic_load();
    logic [15:0] q;
    push(16'h1234, 1'b0);
    push(16'hABCD, 1'b0);
    n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL basic_out_in_load: got %h want 0000", out); end
    n_cmp++; if (run !== 1'b0) begin n_err++; $display("FAIL basic_run_early: got %b want 0", run); end
    push(16'hBEEF, 1'b1);
    n_cmp++; if (run !== 1'b1) begin n_err++; $display("FAIL basic_run: got %b want 1", run); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_drop: got %b want 0", ld_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %b want 0", overflow); end
    cpu_read(6'd8, q);
    n_cmp++; if (q !== 16'h1234) begin n_err++; $display("FAIL basic_rd8: got %h want 1234", q); end
    cpu_read(6'd9, q);
    n_cmp++; if (q !== 16'hABCD) begin n_err++; $display("FAIL basic_rd9: got %h want abcd", q); end
    cpu_read(6'd10, q);
    n_cmp++; if (q !== 16'hBEEF) begin n_err++; $display("FAIL basic_rd10: got %h want beef", q); end
  endtask

  task automatic test_stalled_load();
    logic [15:0] q;
    do_reset();
    push(16'h0001, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 1", i, ld_ready); end
      n_cmp++; if (run !== 1'b0) begin n_err++; $display("FAIL stall_run[%0d]: got %b want 0", i, run); end
    end
    push(16'h0002, 1'b1);
    n_cmp++; if (run !== 1'b1) begin n_err++; $display("FAIL stall_run_end: got %b want 1", run); end
    cpu_read(6'd8, q);
    n_cmp++; if (q !== 16'h0001) begin n_err++; $display("FAIL stall_rd8: got %h want 0001", q); end
    cpu_read(6'd9, q);
    n_cmp++; if (q !== 16'h0002) begin n_err++; $display("FAIL stall_rd9: got %h want 0002", q); end
    cpu_read(6'd10, q);
    n_cmp++; if (q !== 16'hBEEF) begin n_err++; $display("FAIL stall_rd10_kept: got %h want beef", q); end
  endtask

  task automatic test_run_rw();
    logic [15:0] q;
    cpu_write(6'd20, 16'h5555);
    cpu_read(6'd20, q);
    n_cmp++; if (q !== 16'h5555) begin n_err++; $display("FAIL rw_rd20: got %h want 5555", q); end
    cpu_write(6'd20, 16'h6666);
    n_cmp++; if (out !== 16'h5555) begin n_err++; $display("FAIL rw_read_first: got %h want 5555", out); end
    cpu_read(6'd20, q);
    n_cmp++; if (q !== 16'h6666) begin n_err++; $display("FAIL rw_rd20_new: got %h want 6666", q); end
  endtask

  task automatic test_load_blocks_write();
    logic [15:0] q;
    do_reset();
    @(negedge clk);
    addr = 6'd20; data = 16'hDEAD; we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL lockout_out[%0d]: got %h want 0000", i, out); end
    end
    push(16'h1234, 1'b1);
    we = 1'b0;
    cpu_read(6'd20, q);
    n_cmp++; if (q !== 16'h6666) begin n_err++; $display("FAIL lockout_rd20: got %h want 6666", q); end
  endtask

  task automatic test_overflow();
    logic [15:0] q;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      push(16'h0100 + 16'(k), 1'b0);
      if (k == 62) begin
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", overflow); end
        n_cmp++; if (run !== 1'b0) begin n_err++; $display("FAIL ovf_run_early: got %b want 0", run); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (run !== 1'b1) begin n_err++; $display("FAIL ovf_run: got %b want 1", run); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready: got %b want 0", ld_ready); end
    cpu_read(6'd7, q);
    n_cmp++; if (q !== 16'h013F) begin n_err++; $display("FAIL ovf_rd7: got %h want 013f", q); end
    cpu_read(6'd8, q);
    n_cmp++; if (q !== 16'h0100) begin n_err++; $display("FAIL ovf_rd8: got %h want 0100", q); end
    cpu_read(6'd20, q);
    n_cmp++; if (q !== 16'h010C) begin n_err++; $display("FAIL ovf_rd20: got %h want 010c", q); end
  endtask

  task automatic test_last_on_wrap();
    logic [15:0] q;
    do_reset();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_ovf_cleared: got %b want 0", overflow); end
    for (int k = 0; k < 64; k++) begin
      push(16'h0200 + 16'(k), k == 63);
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_last_ovf: got %b want 0", overflow); end
    n_cmp++; if (run !== 1'b1) begin n_err++; $display("FAIL wrap_last_run: got %b want 1", run); end
    cpu_read(6'd7, q);
    n_cmp++; if (q !== 16'h023F) begin n_err++; $display("FAIL wrap_rd7: got %h want 023f", q); end
  endtask

  task automatic test_mid_load_reset();
    logic [15:0] q;
    do_reset();
    push(16'hAAAA, 1'b0);
    push(16'hBBBB, 1'b0);
    n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready_before: got %b want 1", ld_ready); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", ld_ready); end
    n_cmp++; if (run !== 1'b0) begin n_err++; $display("FAIL midrst_run: got %b want 0", run); end
    n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL midrst_out: got %h want 0000", out); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(16'h00FF, 1'b1);
    cpu_read(6'd8, q);
    n_cmp++; if (q !== 16'h00FF) begin n_err++; $display("FAIL midrst_rd8: got %h want 00ff", q); end
    cpu_read(6'd9, q);
    n_cmp++; if (q !== 16'hBBBB) begin n_err++; $display("FAIL midrst_rd9: got %h want bbbb", q); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_stalled_load();
    test_run_rw();
    test_load_blocks_write();
    test_overflow();
    test_last_on_wrap();
    test_mid_load_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
